// File: rtl/mbm_pkg.sv
// mbm_pkg: shared definitions for the minimally-biased Mitchell (MBM) multiplier.
//   clog2        - constant ceil(log2) helper
//   MAX_W/MAX_F  - widest supported operand / fraction width
//   KW           - exponent field width, wide enough for any sum of two exponents plus carry
//   CORR_DEFAULT - default bias correction (10, about 2^7/12 for 7-bit fractions)
//   lod_t, add_t - stage payloads, sized for MAX_W so every WIDTH shares one type
package mbm_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned MAX_W        = 32;
  localparam int unsigned MAX_F        = MAX_W - 1;
  localparam int unsigned KW           = clog2(MAX_W) + 1;
  localparam int unsigned CORR_DEFAULT = 10;

  typedef struct packed {
    logic [KW-1:0]    k;   // leading-one index
    logic [MAX_F-1:0] x;   // fraction, left-aligned to F bits (upper bits zero)
    logic             z;   // operand was zero
  } lod_t;

  typedef struct packed {
    logic [KW-1:0]    ks;  // exponent sum including fraction carry
    logic [MAX_F-1:0] fr;  // corrected, saturated fraction (F bits used)
    logic             z;   // product forced to zero
  } add_t;

endpackage

// File: rtl/mbm_lod.sv
// mbm_lod: combinational leading-one detector and fraction aligner.
//   i_op  - unsigned operand, WIDTH bits
//   o_lod - k = leading-one index, x = bits below it left-aligned into
//           F = WIDTH-1 bits, z = operand is zero
module mbm_lod
  import mbm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_op,
  output lod_t             o_lod
);

  localparam int unsigned F = WIDTH - 1;

  logic [MAX_W-1:0] w_opx;
  logic [KW-1:0]    w_k;
  logic [MAX_W-1:0] w_rem;

  assign w_opx = MAX_W'(i_op);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (w_opx[i[4:0]]) w_k = KW'(i);
    end
  end

  // Strip the leading one, then shift the remainder up so its MSB lands at bit F-1.
  assign w_rem   = w_opx & ~(MAX_W'(1) << w_k);
  assign o_lod.k = w_k;
  assign o_lod.x = MAX_F'(w_rem << (KW'(F) - w_k));
  assign o_lod.z = (i_op == '0);

endmodule

// File: rtl/mbm_log_mult_pipe.sv
// mbm_log_mult_pipe: three-stage pipelined minimally-biased Mitchell multiplier.
//   Stage 1 LOD, stage 2 log add + bias correction, stage 3 antilog shift.
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - operand handshake; in_a, in_b operands; in_tag side-band
//   out_valid/out_ready - product handshake; out_p approximate product,
//                         out_tag echoed tag, out_zero an operand was zero
// Build option: define MBM_RND_EN to round the antilog half-up instead of truncating.
module mbm_log_mult_pipe
  import mbm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CORR  = CORR_DEFAULT,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);

  localparam int unsigned    F    = WIDTH - 1;
  localparam int unsigned    PW   = 2 * WIDTH + F;
  localparam logic [MAX_W-1:0] FMAX = (MAX_W'(1) << F) - MAX_W'(1);

  // Global stall: the whole pipe freezes while the output is blocked.
  logic w_stall;
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  // Stage 1 inputs
  lod_t w_lod_a, w_lod_b;

  mbm_lod #(.WIDTH(WIDTH)) u_lod_a (.i_op(in_a), .o_lod(w_lod_a));
  mbm_lod #(.WIDTH(WIDTH)) u_lod_b (.i_op(in_b), .o_lod(w_lod_b));

  logic             r_v1, r_v2;
  lod_t             r_a1, r_b1;
  add_t             r_add2;
  logic [TAG_W-1:0] r_t1, r_t2;

  // Stage 2: log-domain add with bias correction
  logic [MAX_W-1:0] w_s, w_sf, w_fr;
  logic             w_carry;
  add_t             w_add;

  always_comb begin
    w_s     = MAX_W'(r_a1.x) + MAX_W'(r_b1.x);
    w_carry = (w_s >> F) != '0;
    w_sf    = w_s & FMAX;
    w_fr    = w_sf + (w_carry ? MAX_W'(CORR >> 1) : MAX_W'(CORR));
    w_add.fr = MAX_F'((w_fr > FMAX) ? FMAX : w_fr);
    w_add.ks = r_a1.k + r_b1.k + KW'(w_carry);
    w_add.z  = r_a1.z | r_b1.z;
  end

  // Stage 3: antilog, M = 1.fr shifted by ks then scaled back by 2^-F
  logic [PW-1:0]      w_m, w_sh, w_shr;
  logic [2*WIDTH-1:0] w_p;

  always_comb begin
    w_m  = PW'(r_add2.fr) | (PW'(1) << F);
    w_sh = w_m << r_add2.ks;
`ifdef MBM_RND_EN
    // Adding half an LSB before the shift equals adding bit F-1 after it.
    w_shr = w_sh + (PW'(1) << (F - 1));
`else
    w_shr = w_sh;
`endif
    w_p = r_add2.z ? '0 : (2*WIDTH)'(w_shr >> F);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
      r_a1      <= '0;
      r_b1      <= '0;
      r_add2    <= '0;
      r_t1      <= '0;
      r_t2      <= '0;
      out_p     <= '0;
      out_tag   <= '0;
      out_zero  <= 1'b0;
    end else if (!w_stall) begin
      r_v1      <= in_valid;
      r_a1      <= w_lod_a;
      r_b1      <= w_lod_b;
      r_t1      <= in_tag;
      r_v2      <= r_v1;
      r_add2    <= w_add;
      r_t2      <= r_t1;
      out_valid <= r_v2;
      out_p     <= w_p;
      out_tag   <= r_t2;
      out_zero  <= r_add2.z;
    end
  end

endmodule

// File: tb/tb_mbm_log_mult_pipe.sv
module tb_mbm_log_mult_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CORR  = 10;
  localparam int unsigned F     = WIDTH - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a = '0;
  logic [WIDTH-1:0]   in_b = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [2*WIDTH-1:0] out_p;
  logic [TAG_W-1:0]   out_tag;
  logic               out_zero;

  mbm_log_mult_pipe #(.WIDTH(WIDTH), .CORR(CORR), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned p;
    int unsigned     tag;
    bit              z;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   accepted;
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: Mitchell approximation computed with real-valued-style integer arithmetic.
  function automatic longint unsigned ref_p(input int unsigned a, input int unsigned b);
    longint unsigned one, fa, fb, s, fr, prod, res;
    int unsigned ka, kb, ks;
    if (a == 0 || b == 0) return 0;
    ka = 0; while ((a >> (ka + 1)) != 0) ka++;
    kb = 0; while ((b >> (kb + 1)) != 0) kb++;
    one = longint'(1) << F;
    fa = ((longint'(a) - (longint'(1) << ka)) * one) / (longint'(1) << ka);
    fb = ((longint'(b) - (longint'(1) << kb)) * one) / (longint'(1) << kb);
    s  = fa + fb;
    ks = ka + kb;
    if (s >= one) begin
      s  = s - one;
      ks = ks + 1;
      fr = s + CORR / 2;
    end else begin
      fr = s + CORR;
    end
    if (fr > one - 1) fr = one - 1;
    prod = (one + fr) * (longint'(1) << ks);
    res  = prod / one;
`ifdef MBM_RND_EN
    res = res + ((prod / (one / 2)) % 2);
`endif
    return res;
  endfunction

  task automatic drive(input int unsigned a, input int unsigned b, input int unsigned tag,
                       input longint unsigned p, input bit z);
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    in_tag   = TAG_W'(tag);
    in_valid = 1'b1;
    cur.p    = p;
    cur.tag  = tag;
    cur.z    = z;
  endtask

  // One clock: check outputs and record transfers at the falling edge,
  // then return just after the rising edge with the new state visible.
  task automatic step();
    @(negedge clk);
    accepted = 1'b0;
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
      end else begin
        chk("out_p", out_p, q[0].p);
        chk("out_tag", out_tag, q[0].tag);
        chk("out_zero", out_zero, q[0].z);
        if (out_ready) void'(q.pop_front());
      end
    end
    if (in_valid && in_ready && !rst) begin
      q.push_back(cur);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int unsigned a, input int unsigned b, input int unsigned tag,
                          input longint unsigned p, input bit z);
    drive(a, b, tag, p, z);
    step();
    chk("accept", accepted, 1);
    in_valid = 1'b0;
    chk("lat_c1", out_valid, 0);
    step();
    chk("lat_c2", out_valid, 0);
    step();
    chk("lat_c3", out_valid, 1);
    step();
    chk("drained", q.size(), 0);
  endtask

  int unsigned ra[8];
  int unsigned rb[8];
  int unsigned n;
  int unsigned a0, b0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_in_ready", in_ready, 1);
    q.delete();
    rst = 1'b0;

    send_one(12, 10, 1, 117, 0);
    send_one(3, 3, 2, 8, 0);
`ifdef MBM_RND_EN
    send_one(3, 5, 3, 15, 0);
`else
    send_one(3, 5, 3, 14, 0);
`endif
    send_one(255, 255, 4, 65280, 0);
    send_one(0, 200, 5, 0, 1);

    // Back-to-back stream with a three-cycle output stall in the middle.
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom_range(0, 255);
      rb[i] = $urandom_range(0, 255);
    end
    n = 0;
    for (int c = 0; c < 60; c++) begin
      if (n == 8 && q.size() == 0) break;
      out_ready = !(c >= 4 && c < 7);
      if (n < 8) drive(ra[n], rb[n], (n + 8) % 16, ref_p(ra[n], rb[n]), (ra[n] == 0 || rb[n] == 0));
      else in_valid = 1'b0;
      step();
      if (c == 4) chk("stall_in_ready", in_ready, 0);
      if (accepted) n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", n, 8);
    chk("stream_drained", q.size(), 0);

    // Reset with three operations in flight.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a0 = $urandom_range(0, 255);
      b0 = $urandom_range(0, 255);
      drive(a0, b0, 12 + j, ref_p(a0, b0), (a0 == 0 || b0 == 0));
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("post_rst_idle", out_valid, 0);
    end
    a0 = $urandom_range(1, 255);
    b0 = $urandom_range(1, 255);
    send_one(a0, b0, 9, ref_p(a0, b0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
